color_pitch_decoder: RTL and testbench

//  Inverse of the z->gray pitch colour map. Watches a 24-bit RGB pixel stream
//  (one frame at a time) and classifies each gray pixel into one of 8 z-buckets.
//  At frame end it picks the most-populated bucket and returns a z estimate over
//  a valid/ready handshake. Sits downstream of the video/overlay path; used to

---
 rtl/pitch_pkg.sv | 33 +++
 rtl/gray_classifier.sv | 65 ++++++
 rtl/color_pitch_decoder.sv | 135 +++++++++++++
 tb/tb_color_pitch_decoder.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pitch_pkg.sv
// Shared definitions for the z <-> gray pitch colour map. The z->colour encoder
// and the colour->z decoder both import this package, so the bucket size and
// the gray level table cannot drift apart.
//   MAX_Z        full-scale z
//   NUM_BUCKETS  number of z-buckets (8)
//   BKT          bucket size in z units (MAX_Z / NUM_BUCKETS, integer divide)
//   LEVEL[k]     gray level drawn for bucket k (255, then 250-25k)
//   state_t      decoder FSM states
//   bucket_z()   centre z of bucket k
package pitch_pkg;

  localparam int MAX_Z       = 300;
  localparam int NUM_BUCKETS = 8;
  localparam int K_W         = $clog2(NUM_BUCKETS);
  localparam int BKT         = MAX_Z / NUM_BUCKETS;

  localparam logic [7:0] LEVEL [NUM_BUCKETS] = '{
    8'd255, 8'd225, 8'd200, 8'd175, 8'd150, 8'd125, 8'd100, 8'd75
  };

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_DRAIN,
    S_SCAN,
    S_OUT
  } state_t;

  function automatic logic [15:0] bucket_z(input logic [K_W-1:0] k);
    return 16'(k) * 16'(BKT) + 16'(BKT / 2);
  endfunction

endpackage

// File: rtl/gray_classifier.sv
// Classifies one RGB pixel against the pitch gray levels, registered.
//   clk        system clock
//   reset_n    asynchronous active-low reset (clears hit only)
//   pix_valid  pixel qualifier (already gated by the caller)
//   pix_color  {R,G,B}, 8 bits each
//   hit        registered: pixel was gray and matched a level
//   k          registered: matched bucket index (meaningful only with hit)
module gray_classifier
  import pitch_pkg::*;
#(
  parameter int TOL    = 12,
  parameter int CH_TOL = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           pix_valid,
  input  logic [23:0]    pix_color,
  output logic           hit,
  output logic [K_W-1:0] k
);

  function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
    logic signed [8:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return (d < 0) ? 8'(-d) : 8'(d);
  endfunction

  logic [7:0]     r, g, b, mx, mn;
  logic           gray;
  logic           hit_c;
  logic [K_W-1:0] k_c;

  always_comb begin
    r  = pix_color[23:16];
    g  = pix_color[15:8];
    b  = pix_color[7:0];
    mx = r;
    mn = r;
    if (g > mx) mx = g;
    if (b > mx) mx = b;
    if (g < mn) mn = g;
    if (b < mn) mn = b;
    gray  = (mx - mn) <= 8'(CH_TOL);
    hit_c = 1'b0;
    k_c   = '0;
    // Levels are 25 apart and TOL <= 12, so at most one bucket can match.
    for (int i = 0; i < NUM_BUCKETS; i++) begin
      if (gray && abs_diff(g, LEVEL[i]) <= 8'(TOL)) begin
        hit_c = 1'b1;
        k_c   = K_W'(i);
      end
    end
  end

  // ---- stage 1: classification register ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) hit <= 1'b0;
    else          hit <= pix_valid & hit_c;
  end

  always_ff @(posedge clk) begin
    k <= k_c;
  end

endmodule

// File: rtl/color_pitch_decoder.sv
// Recovers a z estimate from a rendered gray pitch indicator. Gray pixels of
// one frame are histogrammed into 8 buckets; at frame end the most populated
// bucket (lowest index on ties) is reported over a valid/ready handshake.
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   frame_start  1-cycle pulse, first cycle of a frame
//   frame_end    1-cycle pulse, after the last pixel of a frame
//   pix_valid    pix_color valid this cycle
//   pix_color    {R,G,B}
//   z_valid      result available, held until accepted
//   z_ready      consumer accepts when z_valid & z_ready
//   z_est        k*B + B/2 for winning bucket k
//   z_bucket     winning bucket index
//   z_miss       winning count below MIN_PIX
//   z_overrun    1-cycle pulse: an unaccepted result was dropped
module color_pitch_decoder
  import pitch_pkg::*;
#(
  parameter int TOL     = 12,
  parameter int CH_TOL  = 4,
  parameter int CNT_W   = 19,
  parameter int MIN_PIX = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frame_start,
  input  logic        frame_end,
  input  logic        pix_valid,
  input  logic [23:0] pix_color,
  output logic        z_valid,
  input  logic        z_ready,
  output logic [15:0] z_est,
  output logic [2:0]  z_bucket,
  output logic        z_miss,
  output logic        z_overrun
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  state_t           state;
  logic             pix_in;
  logic             hit_p1;
  logic [K_W-1:0]   k_p1;
  logic [CNT_W-1:0] cnt [NUM_BUCKETS];
  logic [K_W-1:0]   scan_k, best_k, nxt_k;
  logic [CNT_W-1:0] best_cnt, nxt_cnt;
  logic             take;

  // A pixel coincident with frame_start belongs to the new frame.
  assign pix_in = pix_valid & (frame_start | (state == S_ACCUM));

  gray_classifier #(
    .TOL    (TOL),
    .CH_TOL (CH_TOL)
  ) u_classify (
    .clk       (clk),
    .reset_n   (reset_n),
    .pix_valid (pix_in),
    .pix_color (pix_color),
    .hit       (hit_p1),
    .k         (k_p1)
  );

  // ---- stage 2: histogram update ----
  // A new frame clears the bank; any stage-1 hit from the old frame is dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_BUCKETS; i++) cnt[i] <= '0;
    end else if (frame_start) begin
      for (int i = 0; i < NUM_BUCKETS; i++) cnt[i] <= '0;
    end else if (hit_p1) begin
      cnt[k_p1] <= sat_inc(cnt[k_p1]);
    end
  end

  // Strict '>' keeps the earliest (lowest k) bucket on ties.
  always_comb begin
    take    = cnt[scan_k] > best_cnt;
    nxt_cnt = take ? cnt[scan_k] : best_cnt;
    nxt_k   = take ? scan_k : best_k;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      scan_k    <= '0;
      best_k    <= '0;
      best_cnt  <= '0;
      z_valid   <= 1'b0;
      z_est     <= '0;
      z_bucket  <= '0;
      z_miss    <= 1'b0;
      z_overrun <= 1'b0;
    end else begin
      z_overrun <= 1'b0;
      if (frame_start) begin
        // A pending result not taken this cycle is lost.
        if (state == S_OUT && !z_ready) z_overrun <= 1'b1;
        z_valid <= 1'b0;
        state   <= S_ACCUM;
      end else begin
        case (state)
          S_IDLE: ;
          S_ACCUM: if (frame_end) state <= S_DRAIN;
          S_DRAIN: begin
            state    <= S_SCAN;
            scan_k   <= '0;
            best_k   <= '0;
            best_cnt <= '0;
          end
          S_SCAN: begin
            best_k   <= nxt_k;
            best_cnt <= nxt_cnt;
            scan_k   <= scan_k + 1'b1;
            if (scan_k == K_W'(NUM_BUCKETS - 1)) begin
              state    <= S_OUT;
              z_valid  <= 1'b1;
              z_bucket <= nxt_k;
              z_est    <= bucket_z(nxt_k);
              z_miss   <= nxt_cnt < CNT_W'(MIN_PIX);
            end
          end
          S_OUT: if (z_ready) begin
            z_valid <= 1'b0;
            state   <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_color_pitch_decoder.sv
module tb_color_pitch_decoder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        frame_start = 1'b0;
  logic        frame_end = 1'b0;
  logic        pix_valid = 1'b0;
  logic [23:0] pix_color = '0;
  logic        z_ready = 1'b0;
  logic        z_valid;
  logic [15:0] z_est;
  logic [2:0]  z_bucket;
  logic        z_miss;
  logic        z_overrun;

  color_pitch_decoder dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .pix_valid   (pix_valid),
    .pix_color   (pix_color),
    .z_valid     (z_valid),
    .z_ready     (z_ready),
    .z_est       (z_est),
    .z_bucket    (z_bucket),
    .z_miss      (z_miss),
    .z_overrun   (z_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int k;
    int est;
    int miss;
  } exp_t;

  exp_t        sb[$];
  logic [23:0] fq[$];
  int          passed = 0;
  int          total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference rules: gray if channel spread <= 4; level 255 for bucket 0,
  // 250-25k otherwise; match if |G - level| <= 12.
  function automatic int level_of(input int k);
    return (k == 0) ? 255 : 250 - 25 * k;
  endfunction

  function automatic int classify(input logic [23:0] p);
    int r, g, b, mx, mn, d;
    r = int'(p[23:16]);
    g = int'(p[15:8]);
    b = int'(p[7:0]);
    mx = (r > g) ? r : g;
    mx = (mx > b) ? mx : b;
    mn = (r < g) ? r : g;
    mn = (mn < b) ? mn : b;
    if (mx - mn > 4) return -1;
    for (int k = 0; k < 8; k++) begin
      d = g - level_of(k);
      if (d < 0) d = -d;
      if (d <= 12) return k;
    end
    return -1;
  endfunction

  function automatic logic [23:0] rgb(input int r, input int g, input int b);
    return {8'(r), 8'(g), 8'(b)};
  endfunction

  function automatic int clamp(input int v);
    return (v < 0) ? 0 : ((v > 255) ? 255 : v);
  endfunction

  task automatic add_px(input logic [23:0] p, input int n);
    for (int i = 0; i < n; i++) fq.push_back(p);
  endtask

  task automatic fill_random(input int n);
    int dom, sel, v, lv;
    fq.delete();
    dom = int'($urandom_range(0, 7));
    for (int i = 0; i < n; i++) begin
      sel = int'($urandom_range(0, 9));
      if (sel <= 3) begin
        v = level_of(dom);
        fq.push_back(rgb(v, v, v));
      end else if (sel <= 6) begin
        lv = level_of(int'($urandom_range(0, 7))) + int'($urandom_range(0, 28)) - 14;
        fq.push_back(rgb(clamp(lv + int'($urandom_range(0, 6)) - 3), clamp(lv),
                         clamp(lv + int'($urandom_range(0, 6)) - 3)));
      end else if (sel <= 8) begin
        fq.push_back(24'($urandom));
      end else begin
        fq.push_back(rgb(255, 255, 255));
      end
    end
  endtask

  task automatic garbage();
    pix_valid   = 1'($urandom_range(0, 1));
    pix_color   = 24'($urandom);
    frame_end   = 1'($urandom_range(0, 1));
    frame_start = 1'b0;
  endtask

  // Plays fq as one frame (first pixel with frame_start, last with frame_end,
  // random gaps between), predicts the result, then runs through DRAIN/SCAN
  // with junk inputs. overrun: a result is pending and gets dropped by this
  // frame_start. abort: assert reset in the middle of SCAN instead.
  task automatic run_frame(input bit overrun, input bit abort);
    int   cnt[8];
    int   idx, c, best, cyc;
    exp_t e;
    for (int i = 0; i < 8; i++) cnt[i] = 0;
    if (overrun && sb.size() > 0) void'(sb.pop_front());
    idx = 0;
    cyc = 0;
    while (idx < fq.size()) begin
      if (idx != 0 && idx != fq.size() - 1 && $urandom_range(0, 3) == 0) begin
        pix_valid   = 1'b0;
        pix_color   = 24'($urandom);
        frame_start = 1'b0;
        frame_end   = 1'b0;
      end else begin
        pix_valid   = 1'b1;
        pix_color   = fq[idx];
        frame_start = (idx == 0);
        frame_end   = (idx == fq.size() - 1);
        c = classify(fq[idx]);
        if (c >= 0) cnt[c]++;
        idx++;
      end
      @(posedge clk); #1;
      cyc++;
      if (overrun && cyc == 1) begin
        chk("overrun_pulse", 32'(z_overrun), 32'd1);
        chk("overrun_valid_low", 32'(z_valid), 32'd0);
      end
      if (overrun && cyc == 2) chk("overrun_one_cycle", 32'(z_overrun), 32'd0);
    end
    frame_start = 1'b0;
    frame_end   = 1'b0;
    best = 0;
    for (int k = 1; k < 8; k++) if (cnt[k] > cnt[best]) best = k;
    e.k    = best;
    e.est  = best * (300 / 8) + (300 / 8) / 2;
    e.miss = (cnt[best] < 16) ? 1 : 0;
    if (abort) begin
      for (int i = 2; i <= 6; i++) begin
        garbage();
        @(posedge clk); #1;
      end
      #2 reset_n = 1'b0;
      #1;
      chk("async_reset_valid", 32'(z_valid), 32'd0);
      chk("async_reset_est", 32'(z_est), 32'd0);
      chk("async_reset_bucket", 32'(z_bucket), 32'd0);
      chk("async_reset_miss", 32'(z_miss), 32'd0);
      pix_valid = 1'b0;
      frame_end = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      return;
    end
    sb.push_back(e);
    for (int i = 2; i <= 10; i++) begin
      garbage();
      @(posedge clk); #1;
      if (i == 9)  chk("latency_not_early", 32'(z_valid), 32'd0);
      if (i == 10) chk("latency_valid", 32'(z_valid), 32'd1);
    end
    pix_valid = 1'b0;
    frame_end = 1'b0;
  endtask

  task automatic hold_stable(input int n);
    logic [31:0] snap;
    snap = {11'd0, z_valid, z_miss, z_bucket, z_est};
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk("hold_stable", {11'd0, z_valid, z_miss, z_bucket, z_est}, snap);
    end
  endtask

  task automatic accept(input int hold);
    hold_stable(hold);
    z_ready = 1'b1;
    @(posedge clk); #1;
    z_ready = 1'b0;
    chk("valid_drop_after_accept", 32'(z_valid), 32'd0);
  endtask

  // Scoreboard monitor: every handshake consumes one predicted result.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n === 1'b1 && z_valid === 1'b1 && z_ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 32'(z_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("z_bucket", 32'(z_bucket), 32'(e.k));
        chk("z_est", 32'(z_est), 32'(e.est));
        chk("z_miss", 32'(z_miss), 32'(e.miss));
      end
    end
  end

  initial begin
    #2 reset_n = 1'b0;
    #1;
    chk("reset_valid", 32'(z_valid), 32'd0);
    chk("reset_est", 32'(z_est), 32'd0);
    chk("reset_bucket", 32'(z_bucket), 32'd0);
    chk("reset_miss", 32'(z_miss), 32'd0);
    chk("reset_overrun", 32'(z_overrun), 32'd0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // Mostly mid-gray with some white: bucket 4.
    fq.delete();
    add_px(rgb(150, 150, 150), 100);
    add_px(rgb(255, 255, 255), 20);
    run_frame(0, 0);
    accept(2);

    // Tie between buckets 1 and 7 resolves to the lower index.
    fq.delete();
    add_px(rgb(225, 225, 225), 50);
    add_px(rgb(75, 75, 75), 50);
    run_frame(0, 0);
    accept(0);

    // Too few pixels: miss flag.
    fq.delete();
    add_px(rgb(200, 200, 200), 10);
    run_frame(0, 0);
    accept(1);

    // Tolerance edges and a non-gray pixel.
    fq.delete();
    add_px(rgb(200, 200, 200), 10);
    add_px(rgb(200, 0, 200), 10);
    add_px(rgb(190, 190, 190), 5);
    add_px(rgb(212, 212, 212), 3);
    add_px(rgb(162, 163, 165), 4);
    run_frame(0, 0);
    accept(0);

    // Last pixel shares the cycle with frame_end and decides the winner.
    fq.delete();
    add_px(rgb(225, 225, 225), 15);
    add_px(rgb(75, 75, 75), 15);
    add_px(rgb(75, 75, 75), 1);
    run_frame(0, 0);
    accept(0);

    // Unaccepted result held, then overrun by the next frame.
    fill_random(40);
    run_frame(0, 0);
    hold_stable(20);
    fill_random(40);
    run_frame(1, 0);
    accept(3);

    // Reset in the middle of SCAN, then a clean frame.
    fill_random(30);
    run_frame(0, 1);
    fill_random(30);
    run_frame(0, 0);
    accept(1);

    for (int f = 0; f < 12; f++) begin
      fill_random(int'($urandom_range(2, 70)));
      run_frame(0, 0);
      accept(int'($urandom_range(0, 5)));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
